// File: rtl/cache_pkg.sv
// Constants and types shared by the L1 cache controller and the L2 responder.
// No logic here: no latency, no backpressure.
package cache_pkg;
    localparam int ADDR_W      = 32;
    localparam int BLOCK_BYTES = 16;
    localparam int OFFSET_W    = 4;
    localparam int TAG_W       = 21;
    localparam int LAT_W       = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ_WAIT,
        ST_WRITE_WAIT,
        ST_RESP
    } resp_state_t;
endpackage

// File: rtl/l2_block_ram.sv
// Single-port block store, 2^INDEX_W x BLOCK_W, no reset on contents.
// Write commits at the clock edge; read data registered, one cycle after re; never stalls.
module l2_block_ram #(
    parameter int INDEX_W = 8,
    parameter int BLOCK_W = 128
) (
    input  logic               clk,
    input  logic               we,
    input  logic               re,
    input  logic [INDEX_W-1:0] idx,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata
);
    logic [BLOCK_W-1:0] mem [2**INDEX_W];

    always_ff @(posedge clk) begin
        if (we) mem[idx] <= wdata;
        if (re) rdata <= mem[idx];
    end
endmodule

// File: rtl/l2_mem_responder.sv
// L2 model below the L1 controller: block reads and writebacks, READ_LAT/WRITE_LAT cycles to the pulse.
// Level requests held by the requester until the pulse; one RESP cycle follows each access, dropping a request aborts it.
module l2_mem_responder
    import cache_pkg::*;
#(
    parameter int INDEX_W   = 8,
    parameter int BLOCK_W   = 128,
    parameter int READ_LAT  = 4,
    parameter int WRITE_LAT = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               read_l2,
    input  logic               write_l2,
    input  logic [ADDR_W-1:0]  addr,
    input  logic [BLOCK_W-1:0] wdata,
    output logic [BLOCK_W-1:0] rdata,
    output logic               l2_ack,
    output logic               write_done,
    output logic               busy
);
    localparam logic [LAT_W-1:0] RD_LOAD = LAT_W'(READ_LAT - 1);
    localparam logic [LAT_W-1:0] WR_LOAD = LAT_W'(WRITE_LAT - 1);

    resp_state_t        state, state_nxt;
    logic [LAT_W-1:0]   cnt;
    logic [INDEX_W-1:0] req_idx, cap_idx, ram_idx;
    logic [BLOCK_W-1:0] cap_wdata, ram_q, rdata_hold;
    logic               accept_wr, accept_rd, launch_now, ram_re;
    logic               unused_addr_bits;

    assign req_idx          = addr[INDEX_W+OFFSET_W-1:OFFSET_W];
    assign unused_addr_bits = ^{addr[OFFSET_W-1:0], addr[ADDR_W-1:INDEX_W+OFFSET_W]};
    assign accept_wr        = (state == ST_IDLE) && write_l2;
    assign accept_rd        = (state == ST_IDLE) && read_l2 && !write_l2;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (accept_wr)          cnt <= WR_LOAD;
            else if (accept_rd)     cnt <= RD_LOAD;
            else if (cnt != '0)     cnt <= cnt - 1'b1;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (write_l2)     state_nxt = ST_WRITE_WAIT;
                else if (read_l2) state_nxt = ST_READ_WAIT;
            end
            ST_READ_WAIT: begin
                if (!read_l2)        state_nxt = ST_IDLE;
                else if (cnt == '0)  state_nxt = ST_RESP;
            end
            ST_WRITE_WAIT: begin
                if (!write_l2)       state_nxt = ST_IDLE;
                else if (cnt == '0)  state_nxt = ST_RESP;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The RAM read is registered, so it is launched one cycle ahead of the ack.
    always_comb begin
        busy       = (state != ST_IDLE);
        l2_ack     = !reset && (state == ST_READ_WAIT) && read_l2 && (cnt == '0);
        write_done = !reset && (state == ST_WRITE_WAIT) && write_l2 && (cnt == '0);
        launch_now = accept_rd && (READ_LAT == 1);
        ram_re     = launch_now || ((state == ST_READ_WAIT) && (cnt == LAT_W'(1)));
        ram_idx    = launch_now ? req_idx : cap_idx;
        rdata      = l2_ack ? ram_q : rdata_hold;
    end

    always_ff @(posedge clk) begin
        if (accept_wr || accept_rd) cap_idx <= req_idx;
        if (accept_wr) cap_wdata <= wdata;
    end

    always_ff @(posedge clk) begin
        if (reset)       rdata_hold <= '0;
        else if (l2_ack) rdata_hold <= ram_q;
    end

    l2_block_ram #(
        .INDEX_W (INDEX_W),
        .BLOCK_W (BLOCK_W)
    ) u_ram (
        .clk   (clk),
        .we    (write_done),
        .re    (ram_re),
        .idx   (ram_idx),
        .wdata (cap_wdata),
        .rdata (ram_q)
    );
endmodule

// File: tb/tb_l2_mem_responder.sv
// Directed bench for l2_mem_responder: scoreboard of expected pulses checked by a negedge monitor.
module tb_l2_mem_responder;
    localparam int RL = 4;
    localparam int WL = 6;
    localparam int BW = 128;

    logic          clk = 1'b0;
    logic          reset;
    logic          read_l2;
    logic          write_l2;
    logic [31:0]   addr;
    logic [BW-1:0] wdata;
    logic [BW-1:0] rdata;
    logic          l2_ack;
    logic          write_done;
    logic          busy;

    int cyc = 0;
    int errors = 0;
    int checks = 0;

    typedef struct {
        bit            is_read;
        logic [BW-1:0] data;
        int            when;
    } exp_t;
    exp_t sb[$];

    logic [BW-1:0] pat_a5, pat_de, pat_c3, pat_5a, last_rd;

    l2_mem_responder #(
        .INDEX_W   (8),
        .BLOCK_W   (BW),
        .READ_LAT  (RL),
        .WRITE_LAT (WL)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read_l2    (read_l2),
        .write_l2   (write_l2),
        .addr       (addr),
        .wdata      (wdata),
        .rdata      (rdata),
        .l2_ack     (l2_ack),
        .write_done (write_done),
        .busy       (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Every pulse must match the oldest outstanding expectation in kind, cycle and data.
    always @(negedge clk) begin
        if (reset === 1'b0 && (l2_ack || write_done)) begin
            if (sb.size() == 0) begin
                chk("spurious_pulse", BW'({l2_ack, write_done}), '0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("pulse_ack", BW'(l2_ack), BW'(e.is_read));
                chk("pulse_wdone", BW'(write_done), BW'(!e.is_read));
                chk("pulse_cycle", BW'(cyc), BW'(e.when));
                if (e.is_read) chk("rdata", rdata, e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full transaction: request held through the RESP cycle, inputs scrambled after capture.
    task automatic tx(input bit rd, input logic [31:0] a, input logic [BW-1:0] d);
        int lat;
        lat = rd ? RL : WL;
        chk("busy_pre", BW'(busy), '0);
        addr = a;
        wdata = d;
        if (rd) read_l2 = 1'b1;
        else write_l2 = 1'b1;
        sb.push_back('{rd, d, cyc + lat});
        for (int k = 1; k <= lat + 1; k++) begin
            step();
            if (k == 2) begin
                addr = ~a;
                wdata = ~d;
            end
            chk("busy_active", BW'(busy), BW'(1));
        end
        read_l2 = 1'b0;
        write_l2 = 1'b0;
        step();
        chk("busy_post", BW'(busy), '0);
        if (rd) last_rd = d;
    endtask

    initial begin
        pat_a5 = {4{32'hA5A5A5A5}};
        pat_de = {4{32'hDEADBEEF}};
        pat_c3 = {4{32'hC3C3C3C3}};
        pat_5a = {4{32'h5A5A5A5A}};
        last_rd = '0;
        reset = 1'b1;
        read_l2 = 1'b0;
        write_l2 = 1'b0;
        addr = '0;
        wdata = '0;
        repeat (3) step();
        chk("rst_ack", BW'(l2_ack), '0);
        chk("rst_wdone", BW'(write_done), '0);
        chk("rst_busy", BW'(busy), '0);
        chk("rst_rdata", rdata, '0);
        reset = 1'b0;
        step();

        // Preload index 0x12, then read it back; also read with nonzero offset bits.
        tx(1'b0, 32'h120, pat_a5);
        tx(1'b1, 32'h120, pat_a5);
        tx(1'b1, 32'h12C, pat_a5);

        // Writeback then refill of the same block at the minimum spacing.
        tx(1'b0, 32'h340, pat_de);
        tx(1'b1, 32'h340, pat_de);

        // Simultaneous requests: write first, read served after RESP.
        begin
            int t0;
            t0 = cyc;
            addr = 32'h560;
            wdata = pat_c3;
            read_l2 = 1'b1;
            write_l2 = 1'b1;
            sb.push_back('{1'b0, pat_c3, t0 + WL});
            sb.push_back('{1'b1, pat_c3, t0 + WL + 2 + RL});
            for (int k = 1; k <= WL + 2 + RL + 1; k++) begin
                step();
                if (k == WL + 1) write_l2 = 1'b0;
                if (k == WL + 2) chk("simul_busy_gap", BW'(busy), '0);
            end
            read_l2 = 1'b0;
            step();
            chk("simul_busy_post", BW'(busy), '0);
            last_rd = pat_c3;
        end

        // Abort: read dropped in cycle 2, no ack, rdata keeps the last read.
        addr = 32'h120;
        read_l2 = 1'b1;
        step();
        step();
        read_l2 = 1'b0;
        step();
        chk("abort_busy", BW'(busy), '0);
        repeat (4) step();
        chk("abort_rdata", rdata, last_rd);

        // Reset in cycle 3 of a write: discarded, outputs cleared, old data survives.
        addr = 32'h340;
        wdata = pat_5a;
        write_l2 = 1'b1;
        repeat (3) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        write_l2 = 1'b0;
        chk("mid_rst_busy", BW'(busy), '0);
        chk("mid_rst_ack", BW'(l2_ack), '0);
        chk("mid_rst_wdone", BW'(write_done), '0);
        chk("mid_rst_rdata", rdata, '0);
        repeat (6) step();
        tx(1'b1, 32'h340, pat_de);

        repeat (4) step();
        chk("rdata_hold_idle", rdata, pat_de);
        chk("sb_drained", BW'(sb.size()), '0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/l2_mem_responder.md
# l2_mem_responder

Memory-side responder for the L1 cache controller's refill/writeback port. It serves block reads (`read_l2` → `l2_ack`) and dirty-block writebacks (`write_l2` → `write_done`) against a block-organised backing store. Each access takes a programmable fixed latency, so L1 miss penalties are realistic in simulation. It sits directly below the L1 controller and models the L2 level in the cache test system.

## Interface
Parameters:
- `INDEX_W`, default 8: block-index width; store holds 2^INDEX_W blocks.
- `BLOCK_W`, default 128: block width in bits (16 bytes, 4 words).
- `READ_LAT`, default 4: cycles from request acceptance to `l2_ack`; legal range 1..15.
- `WRITE_LAT`, default 6: cycles from request acceptance to `write_done`; legal range 1..15.

Ports:
- `clk`, in, 1: the single clock.
- `reset`, in, 1: synchronous, active-high.
- `read_l2`, in, 1: block read request, level, held by requester until `l2_ack`.
- `write_l2`, in, 1: writeback request, level, held by requester until `write_done`.
- `addr`, in, 32: byte address. Block index = `addr[INDEX_W+3:4]`; offset bits [3:0] ignored.
- `wdata`, in, BLOCK_W: writeback block data.
- `rdata`, out, BLOCK_W: read block data, valid in the `l2_ack` cycle and held until the next read completes.
- `l2_ack`, out, 1: one-cycle pulse, read data ready.
- `write_done`, out, 1: one-cycle pulse, writeback committed.
- `busy`, out, 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, READ_WAIT, WRITE_WAIT, RESP.
- IDLE:
  - `write_l2`=1 → capture `addr` and `wdata`, load counter with WRITE_LAT-1, go to WRITE_WAIT.
  - Else `read_l2`=1 → capture `addr`, load counter with READ_LAT-1, go to READ_WAIT.
  - Write wins on simultaneous requests, because a writeback always precedes the refill.
- READ_WAIT: counter decrements each cycle.
  - At 0: read block at the captured index into `rdata`, pulse `l2_ack`, go to RESP.
- WRITE_WAIT: counter decrements each cycle.
  - At 0: write captured `wdata` to the captured index, pulse `write_done`, go to RESP.
- Abort: the request dropping while in a WAIT state returns the FSM to IDLE next cycle.
  - No pulse, no store write, `rdata` unchanged.
- RESP: one mandatory idle cycle; requests are ignored, then go to IDLE. This prevents re-triggering on a request that is still high in the ack cycle.
- Captured `addr`/`wdata` are used for the access; input changes during a WAIT state are ignored.
- Store contents are not reset. Only the FSM and outputs reset.

## Timing
- Reset values: `l2_ack`=0, `write_done`=0, `busy`=0, `rdata`=0, state IDLE, counter 0.
- Request high in IDLE at cycle 0 → pulse at cycle READ_LAT (or WRITE_LAT). `busy` is high in cycles 1..LAT+1.
- Minimum request-to-request spacing: LAT+2 cycles (accept, LAT-1 wait cycles, ack, RESP).
- A write committed at cycle N is visible to a read accepted at cycle N+2 or later; no forwarding is needed.
- Read-after-writeback of the same index returns the new data.
- Reset asserted mid-operation: IDLE next cycle, no pulse. A pending write is discarded and the store is unchanged.
- Both requests low in IDLE: outputs hold, `rdata` keeps its last value.

## Structure
- Shared package `cache_pkg`: ADDR_W=32, BLOCK_BYTES=16, OFFSET_W=4, TAG_W=21 (tag = `addr[31:11]`), and the responder state enum. The L1 controller uses the same constants.
- Sub-module `l2_block_ram`: single-port synchronous RAM with 2^INDEX_W × BLOCK_W, write enable, and registered read. The FSM accounts for the one-cycle read by launching the read when the counter hits 1, or in the accept cycle when LAT=1.

## Test plan
- Read, READ_LAT=4: preload index 0x12 = 0xA5A5…; `read_l2`, `addr`=0x120 at cycle 0 → `l2_ack` exactly at cycle 4 with that `rdata`, `busy` cycles 1–5, no second ack with request still high in cycle 4.
- Writeback then refill: `write_l2`, `addr`=0x340, `wdata`=0xDEADBEEF… → `write_done` at cycle 6. Then `read_l2` same addr at cycle 8 → `l2_ack` at cycle 12 with 0xDEADBEEF….
- Simultaneous `read_l2`=`write_l2`=1 → WRITE_WAIT taken, `write_done` first; the read is served only after RESP.
- Abort: `read_l2` dropped at cycle 2 of a READ_LAT=4 access → no `l2_ack`, `rdata` unchanged, `busy`=0 by cycle 3.
- Reset at cycle 3 of a write → no `write_done`; a later read of that index returns the old contents; all outputs 0 after reset.
- Closed loop with the L1 controller: dirty miss → WriteBack/Allocate sequence completes, and the controller returns to CompareTag with a hit.
